// File: rtl/pipe_rf_write_ctrl_if.sv
// Bundle between the W pipeline stage, the debug/loader requester and the register-file write port.
// The pipeline side uses the master modport and the write controller uses the slave modport.
interface pipe_rf_write_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              W_valid;
  logic [3:0]        W_stat;
  logic [3:0]        W_icode;
  logic [3:0]        W_dstE;
  logic [3:0]        W_dstM;
  logic [DATA_W-1:0] W_valE;
  logic [DATA_W-1:0] W_valM;
  logic              dbg_req;
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_stall;
  logic              halted;

  modport master (
    output W_valid, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
    output dbg_req, dbg_addr, dbg_wdata,
    input  dbg_ack, rf_we, rf_waddr, rf_wdata, wb_stall, halted
  );

  modport slave (
    input  W_valid, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
    input  dbg_req, dbg_addr, dbg_wdata,
    output dbg_ack, rf_we, rf_waddr, rf_wdata, wb_stall, halted
  );
endinterface

// File: rtl/pipe_rf_write_ctrl.sv
// Write-port controller for the Y86 register file: serializes popq dual writebacks, shares the
// port with a debug requester under bounded starvation, latches halt. Optional: WB_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | accepting W bundles; debug may be granted
// PEND_M | captured M write issues this cycle; W stalled, debug held off
module pipe_rf_write_ctrl #(
  parameter int         DATA_W       = 64,
  parameter int         DBG_MAX_WAIT = 8,
  parameter logic [3:0] RNONE        = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_rf_write_ctrl_if.slave  bus
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_dual,
  output logic [31:0]          perf_dbg_force
`endif
);
  localparam logic [7:0] MAX_WAIT = 8'(DBG_MAX_WAIT);
  localparam logic [3:0] STAT_AOK = 4'd1;

  typedef enum logic {IDLE, PEND_M} state_t;

  state_t            state, state_nxt;
  logic [7:0]        wait_cnt;
  logic [3:0]        pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              halted_q;
  logic              rf_we_q, dbg_ack_q;
  logic [3:0]        rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic              need_e, need_m, forced, stall, consume, wr_ok;
  logic              dbg_grant, nxt_we, nxt_ack;
  logic [3:0]        nxt_addr;
  logic [DATA_W-1:0] nxt_data;

  assign need_e  = (bus.W_icode inside {4'h2, 4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB})
                   && (bus.W_dstE != RNONE);
  assign need_m  = (bus.W_icode inside {4'h5, 4'hB}) && (bus.W_dstM != RNONE);
  assign forced  = (state == IDLE) && bus.dbg_req && (wait_cnt == MAX_WAIT);
  assign stall   = (state == PEND_M) || forced;
  assign consume = bus.W_valid && !stall;
  // Once halted, or on a non-AOK bundle, the bundle is swallowed without a write.
  assign wr_ok   = consume && (bus.W_stat == STAT_AOK) && !halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!forced && wr_ok && need_e && need_m) state_nxt = PEND_M;
      PEND_M: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dbg_grant = 1'b0;
    nxt_we    = 1'b0;
    nxt_ack   = 1'b0;
    nxt_addr  = RNONE;
    nxt_data  = '0;
    case (state)
      IDLE: begin
        if (forced) begin
          dbg_grant = 1'b1;
        end else if (wr_ok && need_e) begin
          nxt_we   = 1'b1;
          nxt_addr = bus.W_dstE;
          nxt_data = bus.W_valE;
        end else if (wr_ok && need_m) begin
          nxt_we   = 1'b1;
          nxt_addr = bus.W_dstM;
          nxt_data = bus.W_valM;
        end else if (bus.dbg_req) begin
          dbg_grant = 1'b1;
        end
      end
      PEND_M: begin
        nxt_we   = 1'b1;
        nxt_addr = pend_addr;
        nxt_data = pend_data;
      end
    endcase
    if (dbg_grant) begin
      nxt_we   = (bus.dbg_addr != RNONE);
      nxt_ack  = 1'b1;
      nxt_addr = bus.dbg_addr;
      nxt_data = bus.dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= RNONE;
      rf_wdata_q <= '0;
      dbg_ack_q  <= 1'b0;
      halted_q   <= 1'b0;
      wait_cnt   <= '0;
      pend_addr  <= RNONE;
      pend_data  <= '0;
    end else begin
      rf_we_q    <= nxt_we;
      rf_waddr_q <= nxt_addr;
      rf_wdata_q <= nxt_data;
      dbg_ack_q  <= nxt_ack;
      if (consume && (bus.W_stat != STAT_AOK)) halted_q <= 1'b1;
      if (!bus.dbg_req || dbg_grant) wait_cnt <= '0;
      else if (wait_cnt != MAX_WAIT) wait_cnt <= wait_cnt + 8'd1;
      if (state == IDLE && state_nxt == PEND_M) begin
        pend_addr <= bus.W_dstM;
        pend_data <= bus.W_valM;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dual      <= '0;
      perf_dbg_force <= '0;
    end else begin
      if (state == IDLE && state_nxt == PEND_M) perf_dual <= perf_dual + 32'd1;
      if (forced) perf_dbg_force <= perf_dbg_force + 32'd1;
    end
  end
`endif

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.dbg_ack  = dbg_ack_q;
  assign bus.wb_stall = stall;
  assign bus.halted   = halted_q;
endmodule

// File: doc/pipe_rf_write_ctrl.md
Name: pipe_rf_write_ctrl

Overview:
- Write-port controller for the Y86 pipeline register file.
- Sits between the W pipeline register and a single-write-port register file. It serializes dual writebacks (popq: dstE and dstM) and shares the port with a debug/loader requester using bounded starvation.
- Asserts a stall back to the pipeline when the port is busy, and latches the machine halt status.

Parameters:
- DATA_W, 64, register data width
- DBG_MAX_WAIT, 8, cycles a pending debug request may lose arbitration before it is forced through (range 1..255)
- RNONE, 4'hF, register ID meaning "no register"

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- W_valid  in  1  W-stage bundle present
- W_stat  in  4  status: 1=AOK, 2=HLT, 3=ADR, 4=INS
- W_icode  in  4  instruction code
- W_dstE  in  4  E destination register
- W_dstM  in  4  M destination register
- W_valE  in  DATA_W  E write data
- W_valM  in  DATA_W  M write data
- dbg_req  in  1  debug write request, held until acknowledged
- dbg_addr  in  4  debug target register
- dbg_wdata  in  DATA_W  debug write data
- dbg_ack  out  1  one-cycle pulse, debug write issued
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  write address
- rf_wdata  out  DATA_W  write data
- wb_stall  out  1  combinational; the W bundle presented this cycle is not consumed
- halted  out  1  sticky; machine stopped

Behaviour:
- Reset (async, rst_n=0) values: rf_we=0, rf_waddr=4'hF, rf_wdata=0, dbg_ack=0, halted=0, state=IDLE, wait counter=0.
- Outputs rf_* and dbg_ack are registered. A write selected in cycle t appears on rf_* in cycle t+1 with rf_we=1 for exactly one cycle.
- needE = icode in {2,3,6,8,9,A,B} and dstE!=RNONE.
- needM = icode in {5,B} and dstM!=RNONE.
- Other icodes (0,1,4,7 and C..F) produce no write.
- A bundle is consumed when W_valid=1 and wb_stall=0.
- State IDLE:
  - Forced debug (dbg_req=1 and wait counter==DBG_MAX_WAIT): grant debug, wb_stall=1, W bundle not consumed.
  - Otherwise, consumed bundle with needE&needM: issue the E write, capture dstM/valM, go to PEND_M.
  - Otherwise, consumed bundle with a single need: issue that write, stay in IDLE.
  - Otherwise, if dbg_req=1 and no pipeline write is issued this cycle: grant debug.
- State PEND_M: wb_stall=1, issue the captured M write, return to IDLE. Debug is never granted in PEND_M.
- M is always written after E, so for popq %rsp the M value wins.
- Debug grant: rf_waddr=dbg_addr, rf_wdata=dbg_wdata, dbg_ack=1 next cycle, wait counter cleared.
- dbg_addr==RNONE is acked with no write (rf_we=0).
- Wait counter: increments each cycle dbg_req=1 and debug is not granted; saturates at DBG_MAX_WAIT; cleared on grant or when dbg_req=0.
- Halt: a consumed bundle with W_stat!=AOK performs no write and sets halted=1. W_stat==0 counts as non-AOK.
  - While halted, W bundles are consumed and discarded (wb_stall=0 unless forced debug).
  - Debug writes continue while halted.
  - halted clears only on reset.
- W_valid=0 in IDLE: no pipeline write; debug may be granted.
- Reset asserted mid-PEND_M: the pending M write is dropped and state returns to IDLE.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- Defined: adds outputs perf_dual [31:0] (PEND_M entries) and perf_dbg_force [31:0] (forced debug grants). Both are 32-bit wrapping counters, reset to 0, incremented on the edge on which the event is registered.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single E write: icode=6, dstE=3, valE=0x10 -> next cycle rf_we=1, waddr=3, wdata=0x10; wb_stall stays 0.
- Dual write popq: icode=B, dstE=4, valE=0x108, dstM=4, valM=0x55 -> cycle t+1 write (4,0x108); cycle t+1 wb_stall=1; cycle t+2 write (4,0x55); the following bundle is consumed at t+2.
- Debug starvation: DBG_MAX_WAIT=3, continuous icode=2 writes plus dbg_req (addr=7, data=0xAB) -> after 3 losses, wb_stall=1 for one cycle; next cycle write (7,0xAB) and dbg_ack=1.
- Halt: bundle with W_stat=2, icode=0 -> halted=1, no write. A later icode=6 bundle produces no write, while a debug write still issues.
- No-write codes: icode=4 (rmmovq) with dstE=2 -> rf_we stays 0. icode=2 with dstE=RNONE -> rf_we stays 0.
- Reset mid-PEND_M: drop rst_n the cycle after a popq is accepted -> no M write; outputs return to reset values immediately.
